// File: rtl/arm_imm_encoder.sv
// Searches for an (imm8, rotate_imm) pair that rotates right by 2*rotate_imm to a 32-bit constant.
// Rotations are checked CHECKS_PER_CYCLE at a time, and the lowest matching rotate wins.
module arm_imm_rot_chk (
    input  logic [31:0] value,
    input  logic [3:0]  rot,
    output logic        hit,
    output logic [7:0]  imm8
);
    logic [5:0]  sh;
    logic [31:0] rol;

    // A right shift by 32 yields 0, so rot=0 reduces to the plain value.
    assign sh   = {1'b0, rot, 1'b0};
    assign rol  = (value << sh) | (value >> (6'd32 - sh));
    assign hit  = (rol[31:8] == 24'd0);
    assign imm8 = rol[7:0];
endmodule

module arm_imm_encoder #(
    parameter int CHECKS_PER_CYCLE = 1,
    parameter bit EARLY_EXIT       = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_value,
    input  logic        req_carry_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_found,
    output logic [7:0]  rsp_imm8,
    output logic [3:0]  rsp_rotate,
    output logic [11:0] rsp_operand12,
    output logic        rsp_carry_out,
    output logic        busy
);
    localparam int N = CHECKS_PER_CYCLE;

    if (N != 1 && N != 2 && N != 4 && N != 8 && N != 16) begin : g_bad_param
        $error("arm_imm_encoder: CHECKS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    state_t state, state_n;

    logic [4:0]  idx;
    logic [31:0] value_r;
    logic        carry_r;
    logic        found_r;
    logic [7:0]  imm_r;
    logic [3:0]  rot_r;

    logic [N-1:0]       lane_hit;
    logic [N-1:0][7:0]  lane_imm;

    for (genvar i = 0; i < N; i++) begin : g_lane
        arm_imm_rot_chk u_chk (
            .value (value_r),
            .rot   (idx[3:0] + 4'(i)),
            .hit   (lane_hit[i]),
            .imm8  (lane_imm[i])
        );
    end

    logic       grp_hit;
    logic [7:0] grp_imm;
    logic [3:0] grp_off;
    logic       last_grp, leave;
    logic       fin_found;
    logic [7:0] fin_imm;
    logic [3:0] fin_rot;

    // Lowest lane wins: scan from the top so lower hits overwrite.
    always_comb begin
        grp_imm = 8'd0;
        grp_off = 4'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (lane_hit[i]) begin
                grp_imm = lane_imm[i];
                grp_off = 4'(i);
            end
        end
    end

    assign grp_hit  = |lane_hit;
    assign last_grp = (idx + 5'(N)) == 5'd16;
    assign leave    = (state == SEARCH) && ((EARLY_EXIT && grp_hit) || last_grp);

    // An earlier group's record always beats the current group.
    assign fin_found = found_r | grp_hit;
    assign fin_imm   = found_r ? imm_r : (grp_hit ? grp_imm : 8'd0);
    assign fin_rot   = found_r ? rot_r : (grp_hit ? idx[3:0] + grp_off : 4'd0);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_valid) state_n = SEARCH;
            SEARCH:  if (leave) state_n = DONE;
            DONE:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= 5'd0;
            value_r       <= 32'd0;
            carry_r       <= 1'b0;
            found_r       <= 1'b0;
            imm_r         <= 8'd0;
            rot_r         <= 4'd0;
            rsp_found     <= 1'b0;
            rsp_imm8      <= 8'd0;
            rsp_rotate    <= 4'd0;
            rsp_carry_out <= 1'b0;
        end else if (state == IDLE) begin
            if (req_valid) begin
                value_r <= req_value;
                carry_r <= req_carry_in;
                idx     <= 5'd0;
                found_r <= 1'b0;
            end
        end else if (state == SEARCH) begin
            idx <= idx + 5'(N);
            if (!found_r && grp_hit) begin
                found_r <= 1'b1;
                imm_r   <= grp_imm;
                rot_r   <= idx[3:0] + grp_off;
            end
            if (leave) begin
                rsp_found     <= fin_found;
                rsp_imm8      <= fin_imm;
                rsp_rotate    <= fin_rot;
                rsp_carry_out <= (fin_found && fin_rot != 4'd0) ? value_r[31] : carry_r;
            end
        end
    end

    assign req_ready     = (state == IDLE);
    assign busy          = (state == SEARCH);
    assign rsp_valid     = (state == DONE);
    assign rsp_operand12 = {rsp_rotate, rsp_imm8};
endmodule

// File: tb/tb_arm_imm_encoder.sv
// Bench for arm_imm_encoder: three configurations (N=1 early exit, N=4 early exit, N=1 full scan)
// share one request stream and are checked against a rotation-search reference model.
module tb_arm_imm_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_carry_in = 1'b0;
    logic        rsp_ready = 1'b0;
    logic [31:0] req_value = 32'd0;

    logic [2:0]        req_ready, rsp_valid, rsp_found, rsp_carry_out, busy;
    logic [2:0][7:0]   rsp_imm8;
    logic [2:0][3:0]   rsp_rotate;
    logic [2:0][11:0]  rsp_operand12;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    arm_imm_encoder #(.CHECKS_PER_CYCLE(1), .EARLY_EXIT(1'b1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[0]),
        .req_value(req_value), .req_carry_in(req_carry_in), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready), .rsp_found(rsp_found[0]), .rsp_imm8(rsp_imm8[0]),
        .rsp_rotate(rsp_rotate[0]), .rsp_operand12(rsp_operand12[0]),
        .rsp_carry_out(rsp_carry_out[0]), .busy(busy[0]));

    arm_imm_encoder #(.CHECKS_PER_CYCLE(4), .EARLY_EXIT(1'b1)) u_n4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[1]),
        .req_value(req_value), .req_carry_in(req_carry_in), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready), .rsp_found(rsp_found[1]), .rsp_imm8(rsp_imm8[1]),
        .rsp_rotate(rsp_rotate[1]), .rsp_operand12(rsp_operand12[1]),
        .rsp_carry_out(rsp_carry_out[1]), .busy(busy[1]));

    arm_imm_encoder #(.CHECKS_PER_CYCLE(1), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready[2]),
        .req_value(req_value), .req_carry_in(req_carry_in), .rsp_valid(rsp_valid[2]),
        .rsp_ready(rsp_ready), .rsp_found(rsp_found[2]), .rsp_imm8(rsp_imm8[2]),
        .rsp_rotate(rsp_rotate[2]), .rsp_operand12(rsp_operand12[2]),
        .rsp_carry_out(rsp_carry_out[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
        if (s == 0) return x;
        return (x >> s) | (x << (32 - s));
    endfunction

    // Try every rotate from 0 up; the first imm8 whose ROR reproduces the value wins.
    function automatic void model(input logic [31:0] v, output logic f,
                                  output logic [7:0] imm, output logic [3:0] rot);
        f = 1'b0; imm = 8'd0; rot = 4'd0;
        for (int r = 0; r < 16 && !f; r++) begin
            for (int c = 0; c < 256 && !f; c++) begin
                if (ror32(32'(c), 2 * r) == v) begin
                    f = 1'b1; imm = 8'(c); rot = 4'(r);
                end
            end
        end
    endfunction

    task automatic wait_rsp(output int lat[3]);
        lat = '{0, 0, 0};
        for (int k = 1; k <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); k++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                if (rsp_valid[d] && lat[d] == 0) lat[d] = k;
        end
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] v, input logic cin,
                             input int lat[3]);
        logic f; logic [7:0] imm; logic [3:0] rot; logic co;
        int exp_lat[3];
        model(v, f, imm, rot);
        co = (f && rot != 4'd0) ? v[31] : cin;
        exp_lat[0] = f ? int'(rot) + 1 : 16;
        exp_lat[1] = f ? int'(rot) / 4 + 1 : 4;
        exp_lat[2] = 16;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("%s d%0d lat", tag, d), 32'(lat[d]), 32'(exp_lat[d]));
            chk($sformatf("%s d%0d found", tag, d), 32'(rsp_found[d]), 32'(f));
            chk($sformatf("%s d%0d imm8", tag, d), 32'(rsp_imm8[d]), 32'(imm));
            chk($sformatf("%s d%0d rot", tag, d), 32'(rsp_rotate[d]), 32'(rot));
            chk($sformatf("%s d%0d op12", tag, d), 32'(rsp_operand12[d]), 32'({rot, imm}));
            chk($sformatf("%s d%0d carry", tag, d), 32'(rsp_carry_out[d]), 32'(co));
        end
    endtask

    task automatic issue(input logic [31:0] v, input logic cin);
        req_value = v; req_carry_in = cin; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_value = $urandom;
        req_carry_in = ~cin;
    endtask

    task automatic release_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " idle"}, 32'(req_ready), 32'h7);
    endtask

    task automatic run_req(input string tag, input logic [31:0] v, input logic cin);
        int lat[3];
        issue(v, cin);
        wait_rsp(lat);
        check_rsp(tag, v, cin, lat);
        release_rsp(tag);
    endtask

    initial begin
        int lat[3];
        logic [35:0] snap_op;
        logic [2:0]  snap_co;
        #1;
        chk("rst req_ready", 32'(req_ready), 32'h7);
        chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        chk("rst found", 32'(rsp_found), 32'h0);
        chk("rst op12", 32'(rsp_operand12), 32'h0);
        chk("rst carry", 32'(rsp_carry_out), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_req("ff", 32'h0000_00FF, 1'b1);
        run_req("ff_c0", 32'h0000_00FF, 1'b0);
        run_req("ff000000", 32'hFF00_0000, 1'b0);
        run_req("f000000f", 32'hF000_000F, 1'b0);
        run_req("3fc", 32'h0000_03FC, 1'b1);
        run_req("101", 32'h0000_0101, 1'b1);
        run_req("zero", 32'h0000_0000, 1'b1);
        run_req("four", 32'h0000_0004, 1'b0);
        run_req("all1", 32'hFFFF_FFFF, 1'b0);

        // Backpressure: responses must hold and new requests must be ignored.
        issue(32'hFF00_0000, 1'b0);
        wait_rsp(lat);
        check_rsp("bp", 32'hFF00_0000, 1'b0, lat);
        snap_op = rsp_operand12;
        snap_co = rsp_carry_out;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_value = 32'h1234_5678;
            @(posedge clk); #1;
            chk("bp hold op12", 32'(rsp_operand12 != snap_op), 32'h0);
            chk("bp hold carry", 32'(rsp_carry_out), 32'(snap_co));
            chk("bp hold valid", 32'(rsp_valid), 32'h7);
            chk("bp req_ready", 32'(req_ready), 32'h0);
        end
        req_valid = 1'b0;
        release_rsp("bp");
        chk("bp rsp_valid low", 32'(rsp_valid), 32'h0);
        run_req("bp next", 32'hF000_000F, 1'b1);

        // Async reset mid-search drops the request.
        issue(32'h0000_0101, 1'b1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid rst busy", 32'(busy), 32'h0);
        chk("mid rst req_ready", 32'(req_ready), 32'h7);
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("mid rst no rsp", 32'(rsp_valid), 32'h0);
        end
        run_req("after rst", 32'h0000_3FC0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] v;
            if ($urandom_range(0, 2) != 0)
                v = ror32(32'($urandom_range(0, 255)), 2 * int'($urandom_range(0, 15)));
            else
                v = $urandom;
            run_req($sformatf("rnd%0d", n), v, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
